// File: rtl/axi_slave_mem_if.sv
// AXI4 single-master bus bundle for axi_slave_mem.
// Signal names follow the S0_* port naming of the memory slave.
interface axi_slave_mem_if;
    logic [3:0]  S0_AWID;
    logic [31:0] S0_AWADDR;
    logic [3:0]  S0_AWLEN;
    logic [2:0]  S0_AWSIZE;
    logic [1:0]  S0_AWBURST;
    logic        S0_AWVALID;
    logic        S0_AWREADY;

    logic [31:0] S0_WDATA;
    logic [3:0]  S0_WSTRB;
    logic        S0_WLAST;
    logic        S0_WVALID;
    logic        S0_WREADY;

    logic [3:0]  S0_BID;
    logic [1:0]  S0_BRESP;
    logic        S0_BVALID;
    logic        S0_BREADY;

    logic [3:0]  S0_ARID;
    logic [31:0] S0_ARADDR;
    logic [3:0]  S0_ARLEN;
    logic [2:0]  S0_ARSIZE;
    logic [1:0]  S0_ARBURST;
    logic        S0_ARVALID;
    logic        S0_ARREADY;

    logic [3:0]  S0_RID;
    logic [31:0] S0_RDATA;
    logic [1:0]  S0_RRESP;
    logic        S0_RLAST;
    logic        S0_RVALID;
    logic        S0_RREADY;

    modport slave (
        input  S0_AWID, S0_AWADDR, S0_AWLEN, S0_AWSIZE, S0_AWBURST, S0_AWVALID,
        input  S0_WDATA, S0_WSTRB, S0_WLAST, S0_WVALID, S0_BREADY,
        input  S0_ARID, S0_ARADDR, S0_ARLEN, S0_ARSIZE, S0_ARBURST, S0_ARVALID, S0_RREADY,
        output S0_AWREADY, S0_WREADY, S0_BID, S0_BRESP, S0_BVALID,
        output S0_ARREADY, S0_RID, S0_RDATA, S0_RRESP, S0_RLAST, S0_RVALID
    );

    modport master (
        output S0_AWID, S0_AWADDR, S0_AWLEN, S0_AWSIZE, S0_AWBURST, S0_AWVALID,
        output S0_WDATA, S0_WSTRB, S0_WLAST, S0_WVALID, S0_BREADY,
        output S0_ARID, S0_ARADDR, S0_ARLEN, S0_ARSIZE, S0_ARBURST, S0_ARVALID, S0_RREADY,
        input  S0_AWREADY, S0_WREADY, S0_BID, S0_BRESP, S0_BVALID,
        input  S0_ARREADY, S0_RID, S0_RDATA, S0_RRESP, S0_RLAST, S0_RVALID
    );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a word-organised memory.
// Independent write and read burst engines, one outstanding burst each.
module axi_slave_mem #(
    parameter int unsigned MEM_WORDS = 256
) (
    input logic            ACLK,
    input logic            ASW_RESET,
    axi_slave_mem_if.slave s0
);
    localparam int unsigned IDX_W       = $clog2(MEM_WORDS);
    localparam logic [32:0] ADDR_LIMIT  = 33'(MEM_WORDS) << 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

    logic [31:0] mem [MEM_WORDS];

    function automatic logic [31:0] wrap_mask(input logic [3:0] len, input logic [2:0] size);
        return (({28'd0, len} + 32'd1) << size) - 32'd1;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] incr;
        logic [31:0] mask;
        incr = 32'd1 << size;
        mask = wrap_mask(len, size);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | ((addr + incr) & mask);
            default: return addr + incr;
        endcase
    endfunction

    // Checks the whole burst up front so every beat of it gets the same response.
    function automatic logic burst_err(input logic [31:0] addr, input logic [3:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] mask;
        logic [32:0] last;
        logic        bad_hdr;
        mask    = wrap_mask(len, size);
        bad_hdr = (burst == 2'b11) || (size > 3'd2) ||
                  ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
        case (burst)
            2'b00:   last = {1'b0, addr};
            2'b10:   last = {1'b0, addr & ~mask} + {1'b0, mask} + 33'd1 - (33'd1 << size);
            default: last = {1'b0, addr} + ({29'd0, len} << size);
        endcase
        return bad_hdr || ({1'b0, addr} >= ADDR_LIMIT) || (last >= ADDR_LIMIT);
    endfunction

    wr_state_e   wr_state_q, wr_state_d;
    logic [3:0]  w_id_q, w_id_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [3:0]  w_len_q, w_len_d;
    logic [2:0]  w_size_q, w_size_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic [3:0]  w_cnt_q, w_cnt_d;
    logic        w_err_q, w_err_d;
    logic        awready_q, wready_q, bvalid_q;
    logic        w_last_beat, w_beat_err, mem_we;

    always_comb begin
        wr_state_d  = wr_state_q;
        w_id_d      = w_id_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_size_d    = w_size_q;
        w_burst_d   = w_burst_q;
        w_cnt_d     = w_cnt_q;
        w_err_d     = w_err_q;
        mem_we      = 1'b0;
        w_last_beat = (w_cnt_q == w_len_q);
        w_beat_err  = w_err_q || (s0.S0_WLAST != w_last_beat);
        unique case (wr_state_q)
            WR_IDLE: begin
                if (s0.S0_AWVALID && awready_q) begin
                    w_id_d     = s0.S0_AWID;
                    w_addr_d   = s0.S0_AWADDR;
                    w_len_d    = s0.S0_AWLEN;
                    w_size_d   = s0.S0_AWSIZE;
                    w_burst_d  = s0.S0_AWBURST;
                    w_cnt_d    = 4'd0;
                    w_err_d    = burst_err(s0.S0_AWADDR, s0.S0_AWLEN, s0.S0_AWSIZE, s0.S0_AWBURST);
                    wr_state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (s0.S0_WVALID && wready_q) begin
                    mem_we   = !w_beat_err;
                    w_err_d  = w_beat_err;
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 4'd1;
                    if (s0.S0_WLAST || w_last_beat) begin
                        wr_state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (s0.S0_BREADY && bvalid_q) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Ready/valid are registered from the next state so they stay low through reset.
    always_ff @(posedge ACLK or posedge ASW_RESET) begin
        if (ASW_RESET) begin
            wr_state_q <= WR_IDLE;
            w_id_q     <= '0;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_size_q   <= '0;
            w_burst_q  <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            w_id_q     <= w_id_d;
            w_addr_q   <= w_addr_d;
            w_len_q    <= w_len_d;
            w_size_q   <= w_size_d;
            w_burst_q  <= w_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
            awready_q  <= (wr_state_d == WR_IDLE);
            wready_q   <= (wr_state_d == WR_DATA);
            bvalid_q   <= (wr_state_d == WR_RESP);
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s0.S0_WSTRB[b]) begin
                    mem[w_addr_q[IDX_W+1:2]][8*b +: 8] <= s0.S0_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign s0.S0_AWREADY = awready_q;
    assign s0.S0_WREADY  = wready_q;
    assign s0.S0_BVALID  = bvalid_q;
    assign s0.S0_BID     = w_id_q;
    assign s0.S0_BRESP   = w_err_q ? RESP_SLVERR : RESP_OKAY;

    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [3:0]  r_len_q, r_len_d;
    logic [2:0]  r_size_q, r_size_d;
    logic [1:0]  r_burst_q, r_burst_d;
    logic [3:0]  r_cnt_q, r_cnt_d;
    logic        arready_q;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [3:0]  rid_q, rid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] r_next_addr;
    logic        ar_err;

    // Read data is sampled before any same-edge write lands, giving pre-write data.
    always_comb begin
        rd_state_d  = rd_state_q;
        r_addr_d    = r_addr_q;
        r_len_d     = r_len_q;
        r_size_d    = r_size_q;
        r_burst_d   = r_burst_q;
        r_cnt_d     = r_cnt_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        r_next_addr = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
        ar_err      = burst_err(s0.S0_ARADDR, s0.S0_ARLEN, s0.S0_ARSIZE, s0.S0_ARBURST);
        unique case (rd_state_q)
            RD_IDLE: begin
                if (s0.S0_ARVALID && arready_q) begin
                    rd_state_d = RD_DATA;
                    r_addr_d   = s0.S0_ARADDR;
                    r_len_d    = s0.S0_ARLEN;
                    r_size_d   = s0.S0_ARSIZE;
                    r_burst_d  = s0.S0_ARBURST;
                    r_cnt_d    = 4'd0;
                    rvalid_d   = 1'b1;
                    rid_d      = s0.S0_ARID;
                    rresp_d    = ar_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_d    = (s0.S0_ARLEN == 4'd0);
                    rdata_d    = ar_err ? 32'd0 : mem[s0.S0_ARADDR[IDX_W+1:2]];
                end
            end
            RD_DATA: begin
                if (s0.S0_RREADY && rvalid_q) begin
                    if (rlast_q) begin
                        rd_state_d = RD_IDLE;
                        rvalid_d   = 1'b0;
                        rlast_d    = 1'b0;
                    end else begin
                        r_addr_d = r_next_addr;
                        r_cnt_d  = r_cnt_q + 4'd1;
                        rlast_d  = ((r_cnt_q + 4'd1) == r_len_q);
                        rdata_d  = rresp_q[1] ? 32'd0 : mem[r_next_addr[IDX_W+1:2]];
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ASW_RESET) begin
        if (ASW_RESET) begin
            rd_state_q <= RD_IDLE;
            r_addr_q   <= '0;
            r_len_q    <= '0;
            r_size_q   <= '0;
            r_burst_q  <= '0;
            r_cnt_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rresp_q    <= '0;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            r_addr_q   <= r_addr_d;
            r_len_q    <= r_len_d;
            r_size_q   <= r_size_d;
            r_burst_q  <= r_burst_d;
            r_cnt_q    <= r_cnt_d;
            arready_q  <= (rd_state_d == RD_IDLE);
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rid_q      <= rid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign s0.S0_ARREADY = arready_q;
    assign s0.S0_RVALID  = rvalid_q;
    assign s0.S0_RLAST   = rlast_q;
    assign s0.S0_RID     = rid_q;
    assign s0.S0_RRESP   = rresp_q;
    assign s0.S0_RDATA   = rdata_q;
endmodule
